// File: rtl/core_mem_pkg.sv
//==== core_mem_pkg -- shared types and defaults for the memory arbiter (rev 1.0) ====
`default_nettype none

package core_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT_I = 2'd1;
   localparam logic [1:0] ST_GRANT_D = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_GRANT_I = ST_GRANT_I,
      S_GRANT_D = ST_GRANT_D,
      S_RESP    = ST_RESP
   } arb_state_e;

   // Counter width able to hold the terminal value; never narrower than one bit.
   function automatic int cnt_width(input int tmo);
      return (tmo < 2) ? 1 : $clog2(tmo + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/core_arb_timer.sv
//==== core_arb_timer -- clear/enable wait counter with terminal count, 0 disables (rev 1.0) ====
`default_nettype none

module core_arb_timer
   import core_mem_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int               CNT_W  = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tc_o = (TIMEOUT != 0) && (cnt_q == TC_VAL);

   // Counting stops at the terminal value so the count can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if ((TIMEOUT != 0) && en_i && !tc_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/core_mem_arbiter.sv
//==== core_mem_arbiter -- IMEM/DMEM to single valid/ready bus, DMEM priority, watchdog (rev 1.0) ====
`default_nettype none

module core_mem_arbiter
   import core_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                CLK,
   input  logic                NRST,
   input  logic                IMEM_REQ,
   input  logic [ADDR_W-1:0]   IMEM_ADDR,
   output logic [DATA_W-1:0]   IMEM_RDATA,
   output logic                HCU_IMEM_BUSY,
   output logic                HCU_IMEM_DONE,
   input  logic                DMEM_REQ,
   input  logic                DMEM_WE,
   input  logic [ADDR_W-1:0]   DMEM_ADDR,
   input  logic [DATA_W-1:0]   DMEM_WDATA,
   input  logic [DATA_W/8-1:0] DMEM_WSTRB,
   output logic [DATA_W-1:0]   DMEM_RDATA,
   output logic                HCU_DMEM_BUSY,
   output logic                HCU_DMEM_DONE,
   output logic                BUS_VALID,
   output logic                BUS_WE,
   output logic [ADDR_W-1:0]   BUS_ADDR,
   output logic [DATA_W-1:0]   BUS_WDATA,
   output logic [DATA_W/8-1:0] BUS_WSTRB,
   input  logic                BUS_READY,
   input  logic [DATA_W-1:0]   BUS_RDATA,
   output logic                ARB_TIMEOUT
);

   arb_state_e          state_q,     state_d;
   logic                bus_valid_q, bus_valid_d;
   logic                bus_we_q,    bus_we_d;
   logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [DATA_W/8-1:0] bus_wstrb_q, bus_wstrb_d;
   logic [DATA_W-1:0]   irdata_q,    irdata_d;
   logic [DATA_W-1:0]   drdata_q,    drdata_d;
   logic                idone_q,     idone_d;
   logic                ddone_q,     ddone_d;
   logic                tmo_q,       tmo_d;

   logic timer_clr;
   logic timer_en;
   logic timer_tc;

   assign timer_clr = (state_q == S_IDLE);
   assign timer_en  = ((state_q == S_GRANT_I) || (state_q == S_GRANT_D)) && !BUS_READY;

   core_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i  (CLK),
      .rst_ni (NRST),
      .clr_i  (timer_clr),
      .en_i   (timer_en),
      .tc_o   (timer_tc)
   );

   always_comb begin
      state_d     = state_q;
      bus_valid_d = bus_valid_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      irdata_d    = irdata_q;
      drdata_d    = drdata_q;
      idone_d     = 1'b0;
      ddone_d     = 1'b0;
      tmo_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (DMEM_REQ) begin
               bus_valid_d = 1'b1;
               bus_we_d    = DMEM_WE;
               bus_addr_d  = DMEM_ADDR;
               bus_wdata_d = DMEM_WDATA;
               bus_wstrb_d = DMEM_WSTRB;
               state_d     = S_GRANT_D;
            end else if (IMEM_REQ) begin
               bus_valid_d = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = IMEM_ADDR;
               bus_wdata_d = '0;
               bus_wstrb_d = '0;
               state_d     = S_GRANT_I;
            end
         end

         // A ready beat in the terminal-count cycle still completes normally.
         S_GRANT_I, S_GRANT_D: begin
            if (BUS_READY || timer_tc) begin
               bus_valid_d = 1'b0;
               tmo_d       = !BUS_READY;
               state_d     = S_RESP;
               if (state_q == S_GRANT_I) begin
                  idone_d  = 1'b1;
                  irdata_d = BUS_READY ? BUS_RDATA : '0;
               end else begin
                  ddone_d = 1'b1;
                  if (!BUS_READY) begin
                     drdata_d = '0;
                  end else if (!bus_we_q) begin
                     drdata_d = BUS_RDATA;
                  end
               end
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q     <= S_IDLE;
         bus_valid_q <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wstrb_q <= '0;
         irdata_q    <= '0;
         drdata_q    <= '0;
         idone_q     <= 1'b0;
         ddone_q     <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_valid_q <= bus_valid_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         irdata_q    <= irdata_d;
         drdata_q    <= drdata_d;
         idone_q     <= idone_d;
         ddone_q     <= ddone_d;
         tmo_q       <= tmo_d;
      end
   end

   assign BUS_VALID     = bus_valid_q;
   assign BUS_WE        = bus_we_q;
   assign BUS_ADDR      = bus_addr_q;
   assign BUS_WDATA     = bus_wdata_q;
   assign BUS_WSTRB     = bus_wstrb_q;
   assign IMEM_RDATA    = irdata_q;
   assign DMEM_RDATA    = drdata_q;
   assign HCU_IMEM_DONE = idone_q;
   assign HCU_DMEM_DONE = ddone_q;
   assign ARB_TIMEOUT   = tmo_q;

   // BUSY stays combinational so the HCU stalls in the same cycle REQ rises.
   assign HCU_IMEM_BUSY = IMEM_REQ & ~idone_q;
   assign HCU_DMEM_BUSY = DMEM_REQ & ~ddone_q;

endmodule

`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
//==== tb_core_mem_arbiter -- vector table, corner sequences and random traffic (rev 1.0) ====
`default_nettype none

module tb_core_mem_arbiter;

   localparam int TOUT = 4;

   logic        CLK, NRST;
   logic        IMEM_REQ, DMEM_REQ, DMEM_WE, BUS_READY;
   logic [31:0] IMEM_ADDR, DMEM_ADDR, DMEM_WDATA, BUS_RDATA;
   logic [3:0]  DMEM_WSTRB;

   logic [31:0] IMEM_RDATA, DMEM_RDATA, BUS_ADDR, BUS_WDATA;
   logic [3:0]  BUS_WSTRB;
   logic        HCU_IMEM_BUSY, HCU_IMEM_DONE, HCU_DMEM_BUSY, HCU_DMEM_DONE;
   logic        BUS_VALID, BUS_WE, ARB_TIMEOUT;

   logic [31:0] IMEM_RDATA_Z, DMEM_RDATA_Z, BUS_ADDR_Z, BUS_WDATA_Z;
   logic [3:0]  BUS_WSTRB_Z;
   logic        HCU_IMEM_BUSY_Z, HCU_IMEM_DONE_Z, HCU_DMEM_BUSY_Z, HCU_DMEM_DONE_Z;
   logic        BUS_VALID_Z, BUS_WE_Z, ARB_TIMEOUT_Z;

   core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TOUT)) dut (
      .CLK(CLK), .NRST(NRST),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
      .HCU_IMEM_BUSY(HCU_IMEM_BUSY), .HCU_IMEM_DONE(HCU_IMEM_DONE),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB), .DMEM_RDATA(DMEM_RDATA),
      .HCU_DMEM_BUSY(HCU_DMEM_BUSY), .HCU_DMEM_DONE(HCU_DMEM_DONE),
      .BUS_VALID(BUS_VALID), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
      .BUS_WDATA(BUS_WDATA), .BUS_WSTRB(BUS_WSTRB),
      .BUS_READY(BUS_READY), .BUS_RDATA(BUS_RDATA), .ARB_TIMEOUT(ARB_TIMEOUT)
   );

   // Watchdog disabled; shares every input with the main instance.
   core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_z (
      .CLK(CLK), .NRST(NRST),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA_Z),
      .HCU_IMEM_BUSY(HCU_IMEM_BUSY_Z), .HCU_IMEM_DONE(HCU_IMEM_DONE_Z),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB), .DMEM_RDATA(DMEM_RDATA_Z),
      .HCU_DMEM_BUSY(HCU_DMEM_BUSY_Z), .HCU_DMEM_DONE(HCU_DMEM_DONE_Z),
      .BUS_VALID(BUS_VALID_Z), .BUS_WE(BUS_WE_Z), .BUS_ADDR(BUS_ADDR_Z),
      .BUS_WDATA(BUS_WDATA_Z), .BUS_WSTRB(BUS_WSTRB_Z),
      .BUS_READY(BUS_READY), .BUS_RDATA(BUS_RDATA), .ARB_TIMEOUT(ARB_TIMEOUT_Z)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] m_ird = '0;
   logic [31:0] m_drd = '0;

   typedef struct {
      bit          d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] brd;
      int          waits;
      logic [31:0] exp_rd;
      bit          exp_to;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Slave side of one transfer: ready after 'waits' low cycles, or never if that exceeds TOUT.
   task automatic serve(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] brd, input int waits,
                        input logic [31:0] exp_rd, input bit exp_to, input string nm);
      int n;
      n = 0;
      while (!BUS_VALID && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk({nm, " grant latency"}, n, 1);
      if (!BUS_VALID) return;
      for (int i = 0; i <= waits && BUS_VALID; i++) begin
         chk({nm, " addr"}, BUS_ADDR, a);
         chk({nm, " we"}, {31'b0, BUS_WE}, {31'b0, d & we});
         chk({nm, " strb"}, {28'b0, BUS_WSTRB}, d ? {28'b0, st} : 32'h0);
         if (d) chk({nm, " wdata"}, BUS_WDATA, wd);
         chk({nm, " owner busy"}, {31'b0, d ? HCU_DMEM_BUSY : HCU_IMEM_BUSY}, 32'h1);
         chk({nm, " other busy"}, {31'b0, d ? HCU_IMEM_BUSY : HCU_DMEM_BUSY},
             {31'b0, d ? IMEM_REQ : DMEM_REQ});
         BUS_READY = (i == waits);
         BUS_RDATA = (i == waits) ? brd : $urandom;
         @(negedge CLK);
         BUS_READY = 1'b0;
      end
      chk({nm, " valid off in resp"}, {31'b0, BUS_VALID}, 32'h0);
      chk({nm, " dmem done"}, {31'b0, HCU_DMEM_DONE}, {31'b0, d});
      chk({nm, " imem done"}, {31'b0, HCU_IMEM_DONE}, {31'b0, !d});
      chk({nm, " timeout flag"}, {31'b0, ARB_TIMEOUT}, {31'b0, exp_to});
      chk({nm, " owner busy resp"}, {31'b0, d ? HCU_DMEM_BUSY : HCU_IMEM_BUSY}, 32'h0);
      if (d) begin
         chk({nm, " dmem rdata"}, DMEM_RDATA, exp_rd);
         chk({nm, " imem rdata kept"}, IMEM_RDATA, m_ird);
         m_drd = exp_rd;
      end else begin
         chk({nm, " imem rdata"}, IMEM_RDATA, exp_rd);
         chk({nm, " dmem rdata kept"}, DMEM_RDATA, m_drd);
         m_ird = exp_rd;
      end
      @(negedge CLK);
      chk({nm, " done one cycle"}, {31'b0, HCU_DMEM_DONE | HCU_IMEM_DONE}, 32'h0);
      chk({nm, " timeout one cycle"}, {31'b0, ARB_TIMEOUT}, 32'h0);
   endtask

   task automatic do_reset();
      NRST = 1'b0;
      IMEM_REQ = 1'b0;
      DMEM_REQ = 1'b0;
      BUS_READY = 1'b0;
      repeat (2) @(negedge CLK);
      NRST = 1'b1;
      m_ird = '0;
      m_drd = '0;
      @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got still running required finish");
      $fatal(1);
   end

   initial begin
      int          mode, w;
      bit          to, seen_z, seen_main, seen_done;
      logic [31:0] brd, er;

      tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0050_0093, 1, 32'h0050_0093, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'h1122_3344, 0, 32'h1122_3344, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'h3, 32'h5555_5555, 3, 32'h1122_3344, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h7777_7777, 5, 32'h0, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 32'h0000_2008, 32'h0, 4'hF, 32'hCAFE_F00D, 4, 32'hCAFE_F00D, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 32'h0000_200C, 32'h0, 4'hF, 32'h9999_9999, 7, 32'h0, 1'b1};
      tbl[6] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 32'hA5A5_A5A5, 2, 32'hA5A5_A5A5, 1'b0};

      NRST = 1'b0;
      IMEM_REQ = 1'b0; IMEM_ADDR = '0;
      DMEM_REQ = 1'b0; DMEM_WE = 1'b0; DMEM_ADDR = '0; DMEM_WDATA = '0; DMEM_WSTRB = '0;
      BUS_READY = 1'b0; BUS_RDATA = '0;

      @(negedge CLK);
      chk("reset valid", {31'b0, BUS_VALID}, 32'h0);
      chk("reset dones", {30'b0, HCU_IMEM_DONE, HCU_DMEM_DONE}, 32'h0);
      chk("reset timeout", {31'b0, ARB_TIMEOUT}, 32'h0);
      chk("reset addr", BUS_ADDR, 32'h0);
      chk("reset rdata", IMEM_RDATA | DMEM_RDATA, 32'h0);
      chk("reset busy", {30'b0, HCU_IMEM_BUSY, HCU_DMEM_BUSY}, 32'h0);
      NRST = 1'b1;
      @(negedge CLK);

      for (int k = 0; k < 7; k++) begin
         if (tbl[k].d) begin
            DMEM_REQ = 1'b1; DMEM_WE = tbl[k].we; DMEM_ADDR = tbl[k].addr;
            DMEM_WDATA = tbl[k].wdata; DMEM_WSTRB = tbl[k].strb;
         end else begin
            IMEM_REQ = 1'b1; IMEM_ADDR = tbl[k].addr;
         end
         serve(tbl[k].d, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].strb, tbl[k].brd,
               tbl[k].waits, tbl[k].exp_rd, tbl[k].exp_to, $sformatf("vec%0d", k));
         IMEM_REQ = 1'b0;
         DMEM_REQ = 1'b0;
      end

      // Contention: both rise together, DMEM must be served first.
      IMEM_REQ = 1'b1; IMEM_ADDR = 32'h0000_0200;
      DMEM_REQ = 1'b1; DMEM_WE = 1'b0; DMEM_ADDR = 32'h0000_2000; DMEM_WSTRB = 4'hF;
      serve(1'b1, 1'b0, 32'h0000_2000, DMEM_WDATA, 4'hF, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, "contend d");
      DMEM_REQ = 1'b0;
      serve(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h0000_0013, 1, 32'h0000_0013, 1'b0, "contend i");
      IMEM_REQ = 1'b0;

      for (int k = 0; k < 40; k++) begin
         mode = $urandom_range(0, 2);
         IMEM_ADDR  = $urandom & 32'hFFFF_FFFC;
         DMEM_ADDR  = $urandom;
         DMEM_WE    = 1'($urandom_range(0, 1));
         DMEM_WDATA = $urandom;
         DMEM_WSTRB = 4'($urandom_range(0, 15));
         IMEM_REQ   = (mode != 1);
         DMEM_REQ   = (mode != 0);
         if (DMEM_REQ) begin
            w   = ($urandom_range(0, 7) == 0) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
            brd = $urandom;
            to  = (w > TOUT);
            er  = to ? 32'h0 : (DMEM_WE ? m_drd : brd);
            serve(1'b1, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB, brd, w, er, to,
                  $sformatf("rnd%0d d", k));
            DMEM_REQ = 1'b0;
         end
         if (IMEM_REQ) begin
            w   = ($urandom_range(0, 7) == 0) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
            brd = $urandom;
            to  = (w > TOUT);
            er  = to ? 32'h0 : brd;
            serve(1'b0, 1'b0, IMEM_ADDR, 32'h0, 4'h0, brd, w, er, to, $sformatf("rnd%0d i", k));
            IMEM_REQ = 1'b0;
         end
      end

      // Zero TIMEOUT: the bus waits indefinitely while the main instance aborts.
      do_reset();
      IMEM_REQ = 1'b1; IMEM_ADDR = 32'h0000_0300;
      seen_z = 1'b0;
      seen_main = 1'b0;
      repeat (30) begin
         @(negedge CLK);
         if (ARB_TIMEOUT_Z || HCU_IMEM_DONE_Z) seen_z = 1'b1;
         if (ARB_TIMEOUT) seen_main = 1'b1;
      end
      chk("tmo0 bus held", {31'b0, BUS_VALID_Z}, 32'h1);
      chk("tmo0 no abort", {31'b0, seen_z}, 32'h0);
      chk("tmo4 aborted", {31'b0, seen_main}, 32'h1);
      IMEM_REQ = 1'b0;

      // Reset asserted mid-cycle during a DMEM grant.
      do_reset();
      DMEM_REQ = 1'b1; DMEM_WE = 1'b1; DMEM_ADDR = 32'h0000_2004;
      DMEM_WDATA = 32'hDEAD_BEEF; DMEM_WSTRB = 4'h3;
      for (int i = 0; i < 5 && !BUS_VALID; i++) @(negedge CLK);
      chk("pre-reset grant", {31'b0, BUS_VALID}, 32'h1);
      @(negedge CLK);
      #2 NRST = 1'b0;
      #1;
      chk("async valid drop", {31'b0, BUS_VALID}, 32'h0);
      chk("async dones", {30'b0, HCU_IMEM_DONE, HCU_DMEM_DONE}, 32'h0);
      chk("async addr clear", BUS_ADDR, 32'h0);
      chk("async wdata clear", BUS_WDATA, 32'h0);
      DMEM_REQ = 1'b0;
      m_ird = '0;
      m_drd = '0;
      @(negedge CLK);
      NRST = 1'b1;
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (HCU_DMEM_DONE || HCU_IMEM_DONE || BUS_VALID) seen_done = 1'b1;
      end
      chk("no done after reset", {31'b0, seen_done}, 32'h0);
      IMEM_REQ = 1'b1; IMEM_ADDR = 32'h0000_0400;
      serve(1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'h0000_0013, 1, 32'h0000_0013, 1'b0, "post-reset fetch");
      IMEM_REQ = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
